// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Default datapath widths match the core; instances may override them.
package wb_port_arbiter_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam logic [REG_AW-1:0] REG_ZERO = '0;

   // Winner of the single write slot in the current cycle.
   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_PIPE = 2'd1,
      GRANT_FIFO = 2'd2
   } grant_e;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Small synchronous FIFO buffering MDU results until a write slot is free.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_port_arbiter_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Requests that would overflow or underflow are ignored.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the WB stage (priority)
// and buffered MDU results, with a starvation counter forcing MDU drains.
module wb_port_arbiter #(
   parameter int XLEN       = wb_port_arbiter_pkg::XLEN,
   parameter int REG_AW     = wb_port_arbiter_pkg::REG_AW,
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipe_wb_valid,
   input  logic [REG_AW-1:0] pipe_wb_rd,
   input  logic [XLEN-1:0]   pipe_wb_data,
   input  logic              mdu_valid,
   input  logic [REG_AW-1:0] mdu_rd,
   input  logic [XLEN-1:0]   mdu_data,
   output logic              mdu_ready,
   output logic              pipe_stall,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              mdu_pending
);

   import wb_port_arbiter_pkg::*;

   localparam int ENTRY_W = REG_AW + XLEN;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int SC_W    = $clog2(STARVE_MAX + 1);
   localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_MAX);

   logic [ENTRY_W-1:0] fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_nonempty;
   logic               fifo_push;
   logic               fifo_pop;
   logic [REG_AW-1:0]  head_rd;
   logic [XLEN-1:0]    head_data;
   logic               pipe_req;
   logic               force_drain;
   logic [SC_W-1:0]    starve_cnt;
   grant_e             grant;

   // MDU handshake: a result transfers on any cycle with mdu_valid && mdu_ready;
   // mdu_ready comes from registered FIFO state only, so a same-cycle pop never
   // opens a slot. Results for x0 complete the handshake but are dropped.
   assign mdu_ready     = !fifo_full;
   assign fifo_push     = mdu_valid && mdu_ready && (mdu_rd != '0);
   assign fifo_nonempty = !fifo_empty;
   assign mdu_pending   = (fifo_count != '0);
   assign pipe_req      = pipe_wb_valid && (pipe_wb_rd != '0);
   assign head_rd       = fifo_dout[ENTRY_W-1:XLEN];
   assign head_data     = fifo_dout[XLEN-1:0];

   wb_port_arbiter_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({mdu_rd, mdu_data}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      grant       = GRANT_NONE;
      pipe_stall  = 1'b0;
      force_drain = fifo_nonempty && (starve_cnt == STARVE_TOP);
      if (force_drain) begin
         grant      = GRANT_FIFO;
         pipe_stall = pipe_req;
      end else if (pipe_req) begin
         grant = GRANT_PIPE;
      end else if (fifo_nonempty) begin
         grant = GRANT_FIFO;
      end
   end

   assign fifo_pop = (grant == GRANT_FIFO);

   // Address and data hold their last value on idle cycles; only rf_we drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         unique case (grant)
            GRANT_PIPE: begin
               rf_we    <= 1'b1;
               rf_waddr <= pipe_wb_rd;
               rf_wdata <= pipe_wb_data;
            end
            GRANT_FIFO: begin
               rf_we    <= 1'b1;
               rf_waddr <= head_rd;
               rf_wdata <= head_data;
            end
            default: rf_we <= 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (fifo_empty || (grant == GRANT_FIFO)) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_TOP) begin
         starve_cnt <= starve_cnt + SC_W'(1);
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized checks of wb_port_arbiter against a queue-based
// model of the write-port sharing rules.
module tb_wb_port_arbiter;

   localparam int XLEN       = 32;
   localparam int REG_AW     = 5;
   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;
   localparam int EW         = REG_AW + XLEN;

   logic              clk;
   logic              rst_n;
   logic              pipe_wb_valid;
   logic [REG_AW-1:0] pipe_wb_rd;
   logic [XLEN-1:0]   pipe_wb_data;
   logic              mdu_valid;
   logic [REG_AW-1:0] mdu_rd;
   logic [XLEN-1:0]   mdu_data;
   logic              mdu_ready;
   logic              pipe_stall;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [XLEN-1:0]   rf_wdata;
   logic              mdu_pending;

   wb_port_arbiter #(
      .XLEN       (XLEN),
      .REG_AW     (REG_AW),
      .FIFO_DEPTH (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pipe_wb_valid (pipe_wb_valid),
      .pipe_wb_rd    (pipe_wb_rd),
      .pipe_wb_data  (pipe_wb_data),
      .mdu_valid     (mdu_valid),
      .mdu_rd        (mdu_rd),
      .mdu_data      (mdu_data),
      .mdu_ready     (mdu_ready),
      .pipe_stall    (pipe_stall),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .mdu_pending   (mdu_pending)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // reference model: buffered MDU results, wait counter, expected write port
   logic [EW-1:0]     exp_q[$];
   int                m_starve;
   logic              exp_we;
   logic [REG_AW-1:0] exp_waddr;
   logic [XLEN-1:0]   exp_wdata;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_starve  = 0;
      exp_we    = 1'b0;
      exp_waddr = '0;
      exp_wdata = '0;
   endtask

   // One clock cycle: drive inputs, check combinational outputs, advance the
   // model, then check the registered write port after the edge.
   task automatic cycle(input logic pv, input logic [REG_AW-1:0] prd, input logic [XLEN-1:0] pd,
                        input logic mv, input logic [REG_AW-1:0] mrd, input logic [XLEN-1:0] md,
                        output logic acc);
      bit preq, nonempty, ready, force_d, g_fifo, g_pipe;
      logic [EW-1:0] head;
      pipe_wb_valid = pv;
      pipe_wb_rd    = prd;
      pipe_wb_data  = pd;
      mdu_valid     = mv;
      mdu_rd        = mrd;
      mdu_data      = md;
      #1;
      nonempty = (exp_q.size() != 0);
      ready    = (exp_q.size() < DEPTH);
      preq     = pv && (prd != 0);
      force_d  = nonempty && (m_starve == STARVE_MAX);
      check("mdu_ready", 64'(mdu_ready), 64'(ready));
      check("mdu_pending", 64'(mdu_pending), 64'(nonempty));
      check("pipe_stall", 64'(pipe_stall), 64'(force_d && preq));
      g_fifo = force_d || (!preq && nonempty);
      g_pipe = !force_d && preq;
      acc    = mv && ready;
      if (g_pipe) begin
         exp_we    = 1'b1;
         exp_waddr = prd;
         exp_wdata = pd;
      end else if (g_fifo) begin
         head      = exp_q.pop_front();
         exp_we    = 1'b1;
         exp_waddr = head[EW-1:XLEN];
         exp_wdata = head[XLEN-1:0];
      end else begin
         exp_we = 1'b0;
      end
      if (!nonempty || g_fifo) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
      if (acc && mrd != 0) exp_q.push_back({mrd, md});
      @(posedge clk);
      #1;
      check("rf_we", 64'(rf_we), 64'(exp_we));
      check("rf_waddr", 64'(rf_waddr), 64'(exp_waddr));
      check("rf_wdata", 64'(rf_wdata), 64'(exp_wdata));
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, acc);
   endtask

   // Holds an MDU result on the bus until it is accepted; pipe optionally busy.
   task automatic mdu_push_held(input logic busy, input logic [REG_AW-1:0] mrd, input logic [XLEN-1:0] md);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 20) begin
         cycle(busy, REG_AW'($urandom_range(1, 31)), $urandom, 1'b1, mrd, md, acc);
         n++;
      end
      check("mdu_accept_within_bound", 64'(acc), 64'(1));
   endtask

   initial begin
      logic              acc;
      logic              hold_v;
      logic [REG_AW-1:0] hold_rd;
      logic [XLEN-1:0]   hold_data;

      rst_n         = 1'b0;
      pipe_wb_valid = 1'b0;
      pipe_wb_rd    = '0;
      pipe_wb_data  = '0;
      mdu_valid     = 1'b0;
      mdu_rd        = '0;
      mdu_data      = '0;
      model_reset();
      #12;
      check("reset_rf_we", 64'(rf_we), 64'(0));
      check("reset_rf_waddr", 64'(rf_waddr), 64'(0));
      check("reset_rf_wdata", 64'(rf_wdata), 64'(0));
      check("reset_mdu_ready", 64'(mdu_ready), 64'(1));
      check("reset_pipe_stall", 64'(pipe_stall), 64'(0));
      check("reset_mdu_pending", 64'(mdu_pending), 64'(0));
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // plain pipe write
      cycle(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, acc);
      check("pipe_write_addr", 64'(rf_waddr), 64'(5));

      // lone MDU result drains through an idle slot
      cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'hDEAD, acc);
      idle(1);
      check("mdu_write_addr", 64'(rf_waddr), 64'(7));
      idle(2);
      check("mdu_fifo_empty", 64'(mdu_pending), 64'(0));

      // busy pipe starves one MDU entry until a forced drain
      cycle(1'b1, 5'd9, 32'h11, 1'b1, 5'd3, 32'h3333, acc);
      for (int i = 0; i < 6; i++) cycle(1'b1, REG_AW'(10 + i), 32'(i), 1'b0, '0, '0, acc);
      idle(1);

      // fill the FIFO under a busy pipe; third result waits for a pop
      mdu_push_held(1'b1, 5'd11, 32'hA0A0_0001);
      mdu_push_held(1'b1, 5'd12, 32'hA0A0_0002);
      mdu_push_held(1'b1, 5'd13, 32'hA0A0_0003);
      for (int i = 0; i < 8; i++) cycle(1'b1, 5'd20, 32'(i), 1'b0, '0, '0, acc);
      idle(3);

      // writes to x0 from both sources
      cycle(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE, acc);
      check("x0_mdu_handshake", 64'(acc), 64'(1));
      idle(2);

      // randomized traffic
      hold_v    = 1'b0;
      hold_rd   = '0;
      hold_data = '0;
      for (int i = 0; i < 400; i++) begin
         if (!hold_v && $urandom_range(0, 2) == 0) begin
            hold_v    = 1'b1;
            hold_rd   = REG_AW'($urandom_range(0, 31));
            hold_data = $urandom;
         end
         cycle($urandom_range(0, 9) < 6, REG_AW'($urandom_range(0, 31)), $urandom,
               hold_v, hold_rd, hold_data, acc);
         if (acc) hold_v = 1'b0;
      end
      idle(4);

      // reset mid-traffic with two results buffered
      cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd21, 32'hB1, acc);
      cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd22, 32'hB2, acc);
      check("pre_reset_full", 64'(mdu_ready), 64'(0));
      pipe_wb_valid = 1'b0;
      mdu_valid     = 1'b0;
      rst_n         = 1'b0;
      #1;
      check("midreset_rf_we", 64'(rf_we), 64'(0));
      check("midreset_mdu_ready", 64'(mdu_ready), 64'(1));
      check("midreset_mdu_pending", 64'(mdu_pending), 64'(0));
      model_reset();
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(3);
      cycle(1'b1, 5'd6, 32'h6666, 1'b1, 5'd8, 32'h8888, acc);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
